regfile_writeback: RTL and testbench

- Write-side front end for the 32x32 register file; the block that drives RegWrite, WriteRegister and WriteData.
- Merges two result sources into the single register-file write port:
  - Port A: single-cycle ALU results, fixed highest priority.
  - Port B: multicycle/load results, buffered in a small FIFO.
- Exports a 32-bit Pending mask so decode can detect reads of registers whose queued writes have not landed.

---
 rtl/regfile_writeback.sv | 114 +++++++++++
 tb/tb_regfile_writeback.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file write front end: merges single-cycle ALU results (port A, priority)
// with queued multicycle/load results (port B) onto one registered write port.
module regfile_writeback #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     AValid,
  input  logic [4:0]               ARegister,
  input  logic [WIDTH-1:0]         AData,
  output logic                     AReady,
  input  logic                     BValid,
  input  logic [4:0]               BRegister,
  input  logic [WIDTH-1:0]         BData,
  output logic                     BReady,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [WIDTH-1:0]         WriteData,
  output logic [31:0]              Pending,
  output logic [$clog2(DEPTH):0]   QueueCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [4:0]       tag_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [31:0]      entry_mask [DEPTH];
  logic [31:0]      pending_mask;
  logic             accept_a;
  logic             pop;
  logic             push;

  // Each live queue slot contributes a one-hot mask of its destination register.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_mask
      assign entry_mask[gi] = valid_reg[gi] ? (32'd1 << tag_mem[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_mask = pending_mask | entry_mask[i];
    end
  end

  assign Pending    = pending_mask & ~32'd1;
  assign QueueCount = count_reg;

  // A must wait behind any older queued write to the same register.
  assign AReady   = !reset && !((ARegister != 5'd0) && pending_mask[ARegister]);
  assign BReady   = !reset && (count_reg < FULL_COUNT);
  assign accept_a = AValid && AReady;
  assign pop      = !accept_a && (count_reg != '0);
  assign push     = BValid && BReady && (BRegister != 5'd0);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Payload storage carries no reset; valid_reg alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[tail_reg]  <= BRegister;
      data_mem[tail_reg] <= BData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg     <= '0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= '0;
    end else begin
      if (accept_a) begin
        RegWrite      <= (ARegister != 5'd0);
        WriteRegister <= ARegister;
        WriteData     <= AData;
      end else if (pop) begin
        RegWrite            <= 1'b1;
        WriteRegister       <= tag_mem[head_reg];
        WriteData           <= data_mem[head_reg];
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + PW'(1);
      end else begin
        RegWrite <= 1'b0;
      end
      // Head and tail never coincide when both push and pop happen.
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic
// compared against a queue-based reference of the write-port behaviour.
module tb_regfile_writeback;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             AValid;
  logic [4:0]       ARegister;
  logic [WIDTH-1:0] AData;
  logic             AReady;
  logic             BValid;
  logic [4:0]       BRegister;
  logic [WIDTH-1:0] BData;
  logic             BReady;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [31:0]      Pending;
  logic [CW-1:0]    QueueCount;

  regfile_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .AValid(AValid), .ARegister(ARegister), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BRegister(BRegister), .BData(BData), .BReady(BReady),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Pending(Pending), .QueueCount(QueueCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       r;
    logic [WIDTH-1:0] d;
  } entry_t;

  entry_t           mq[$];
  logic             m_rw = 1'b0;
  logic [4:0]       m_wr = 5'd0;
  logic [WIDTH-1:0] m_wd = '0;
  logic [WIDTH-1:0] seen_rf [32];
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].r] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic m_aready();
    logic [31:0] p = m_pending();
    return !reset && !((ARegister != 5'd0) && p[ARegister]);
  endfunction

  function automatic logic m_bready();
    return !reset && (mq.size() < DEPTH);
  endfunction

  // One clock: the reference applies the issue rules at the edge, then outputs settle.
  task automatic tick();
    logic   ar;
    logic   br;
    entry_t e;
    ar = m_aready();
    br = m_bready();
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_rw = 1'b0;
      m_wr = 5'd0;
      m_wd = '0;
    end else begin
      if (AValid && ar) begin
        m_rw = (ARegister != 5'd0);
        m_wr = ARegister;
        m_wd = AData;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_rw = 1'b1;
        m_wr = e.r;
        m_wd = e.d;
      end else begin
        m_rw = 1'b0;
      end
      if (BValid && br && (BRegister != 5'd0)) begin
        e.r = BRegister;
        e.d = BData;
        mq.push_back(e);
      end
    end
    @(negedge clk);
    if (RegWrite === 1'b1) begin
      seen_rf[WriteRegister] = WriteData;
      $display("write r%0d <= %h", WriteRegister, WriteData);
    end
  endtask

  task automatic idle_inputs();
    AValid = 1'b0; ARegister = 5'd0; AData = '0;
    BValid = 1'b0; BRegister = 5'd0; BData = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    AValid = 1'b1; ARegister = 5'd3; AData = 32'h11;
    BValid = 1'b1; BRegister = 5'd4; BData = 32'h22;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (AReady !== 1'b0) begin failures++; $display("FAIL reset_aready got=%b want=0", AReady); end
      checks++; if (BReady !== 1'b0) begin failures++; $display("FAIL reset_bready got=%b want=0", BReady); end
      tick();
      checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b want=0", RegWrite); end
    end
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (QueueCount !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d want=0", QueueCount); end
    checks++; if (Pending !== 32'd0) begin failures++; $display("FAIL reset_pending got=%h want=0", Pending); end
    checks++; if (WriteRegister !== 5'd0 || WriteData !== '0) begin failures++; $display("FAIL reset_wout got=%0d/%h want=0/0", WriteRegister, WriteData); end
    tick();
  endtask

  task automatic test_a_only();
    AValid = 1'b1; ARegister = 5'd5; AData = 32'hDEADBEEF;
    #1;
    checks++; if (AReady !== 1'b1) begin failures++; $display("FAIL a_only_ready got=%b want=1", AReady); end
    tick();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      failures++; $display("FAIL a_only_issue got=%b/%0d/%h want=1/5/deadbeef", RegWrite, WriteRegister, WriteData); end
    idle_inputs();
    tick();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL a_only_after got=%b want=0", RegWrite); end
  endtask

  task automatic test_fill_arbitrate();
    for (int i = 0; i < 4; i++) begin
      AValid = 1'b1; ARegister = 5'(i + 1); AData = $urandom;
      BValid = 1'b1; BRegister = 5'(8 + i); BData = 32'h100 + 32'(i);
      #1;
      checks++; if (BReady !== 1'b1) begin failures++; $display("FAIL fill_bready_%0d got=%b want=1", i, BReady); end
      tick();
    end
    AValid = 1'b1; ARegister = 5'd5; BValid = 1'b1; BRegister = 5'd12;
    #1;
    checks++; if (BReady !== 1'b0) begin failures++; $display("FAIL fill_full_bready got=%b want=0", BReady); end
    checks++; if (QueueCount !== CW'(4)) begin failures++; $display("FAIL fill_count got=%0d want=4", QueueCount); end
    checks++; if (Pending !== 32'h0000_0F00) begin failures++; $display("FAIL fill_pending got=%h want=00000f00", Pending); end
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(8 + i) || WriteData !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL drain_%0d got=%b/%0d/%h want=1/%0d/%h", i, RegWrite, WriteRegister, WriteData, 8 + i, 32'h100 + 32'(i)); end
    end
    checks++; if (QueueCount !== CW'(0)) begin failures++; $display("FAIL drain_count got=%0d want=0", QueueCount); end
  endtask

  task automatic test_waw();
    AValid = 1'b1; ARegister = 5'd3; AData = 32'h33;
    BValid = 1'b1; BRegister = 5'd7; BData = 32'd1;
    tick();
    AValid = 1'b1; ARegister = 5'd7; AData = 32'd2; BValid = 1'b0;
    #1;
    checks++; if (AReady !== 1'b0 || Pending[7] !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b/%b want=0/1", AReady, Pending[7]); end
    tick();
    checks++; if (WriteRegister !== 5'd7 || WriteData !== 32'd1 || RegWrite !== 1'b1) begin
      failures++; $display("FAIL waw_first got=%b/%0d/%h want=1/7/1", RegWrite, WriteRegister, WriteData); end
    #1;
    checks++; if (AReady !== 1'b1) begin failures++; $display("FAIL waw_release got=%b want=1", AReady); end
    tick();
    checks++; if (WriteRegister !== 5'd7 || WriteData !== 32'd2 || RegWrite !== 1'b1) begin
      failures++; $display("FAIL waw_second got=%b/%0d/%h want=1/7/2", RegWrite, WriteRegister, WriteData); end
    idle_inputs();
    tick();
    checks++; if (seen_rf[7] !== 32'd2) begin failures++; $display("FAIL waw_final got=%h want=2", seen_rf[7]); end
  endtask

  task automatic test_reg0();
    AValid = 1'b1; ARegister = 5'd0; AData = 32'hABCD;
    #1;
    checks++; if (AReady !== 1'b1) begin failures++; $display("FAIL r0_aready got=%b want=1", AReady); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL r0_a_regwrite got=%b want=0", RegWrite); end
    AValid = 1'b0; BValid = 1'b1; BRegister = 5'd0; BData = 32'h1234;
    #1;
    checks++; if (BReady !== 1'b1) begin failures++; $display("FAIL r0_bready got=%b want=1", BReady); end
    tick();
    checks++; if (QueueCount !== CW'(0) || Pending[0] !== 1'b0) begin failures++; $display("FAIL r0_b_drop got=%0d/%b want=0/0", QueueCount, Pending[0]); end
    idle_inputs();
    tick();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL r0_b_noissue got=%b want=0", RegWrite); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      AValid = 1'b1; ARegister = 5'(i + 1); AData = $urandom;
      BValid = 1'b1; BRegister = 5'(12 + i); BData = $urandom;
      tick();
    end
    checks++; if (QueueCount !== CW'(3)) begin failures++; $display("FAIL mid_count_pre got=%0d want=3", QueueCount); end
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (QueueCount !== CW'(0) || Pending !== 32'd0) begin failures++; $display("FAIL mid_cleared got=%0d/%h want=0/0", QueueCount, Pending); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL mid_noissue got=%b want=0", RegWrite); end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 2; i++) begin
      AValid = 1'b1; ARegister = 5'(i + 1); AData = $urandom;
      BValid = 1'b1; BRegister = 5'(16 + i); BData = 32'h16 + 32'(i);
      tick();
    end
    AValid = 1'b0; BValid = 1'b1; BRegister = 5'd18; BData = 32'h18;
    #1;
    checks++; if (QueueCount !== CW'(2) || BReady !== 1'b1) begin failures++; $display("FAIL pp_pre got=%0d/%b want=2/1", QueueCount, BReady); end
    tick();
    checks++; if (QueueCount !== CW'(2)) begin failures++; $display("FAIL pp_count got=%0d want=2", QueueCount); end
    checks++; if (Pending !== 32'h0006_0000) begin failures++; $display("FAIL pp_pending got=%h want=00060000", Pending); end
    checks++; if (WriteRegister !== 5'd16 || WriteData !== 32'h16) begin failures++; $display("FAIL pp_pop0 got=%0d/%h want=16/16", WriteRegister, WriteData); end
    idle_inputs();
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if (WriteRegister !== 5'(16 + i) || WriteData !== 32'h16 + 32'(i)) begin
        failures++; $display("FAIL pp_pop%0d got=%0d/%h want=%0d/%h", i, WriteRegister, WriteData, 16 + i, 32'h16 + 32'(i)); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      AValid    = ($urandom_range(0, 2) == 0);
      ARegister = 5'($urandom_range(0, 7));
      AData     = $urandom;
      BValid    = 1'($urandom_range(0, 1));
      BRegister = 5'($urandom_range(0, 7));
      BData     = $urandom;
      #1;
      checks++; if (AReady !== m_aready()) begin failures++; $display("FAIL rnd_aready cyc=%0d got=%b want=%b", i, AReady, m_aready()); end
      checks++; if (BReady !== m_bready()) begin failures++; $display("FAIL rnd_bready cyc=%0d got=%b want=%b", i, BReady, m_bready()); end
      checks++; if (Pending !== m_pending()) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%h want=%h", i, Pending, m_pending()); end
      checks++; if (QueueCount !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, QueueCount, mq.size()); end
      tick();
      checks++; if (RegWrite !== m_rw || WriteRegister !== m_wr || WriteData !== m_wd) begin
        failures++; $display("FAIL rnd_write cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", i, RegWrite, WriteRegister, WriteData, m_rw, m_wr, m_wd); end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    foreach (seen_rf[i]) seen_rf[i] = '0;
    test_reset();
    test_a_only();
    test_fill_arbitrate();
    test_waw();
    test_reg0();
    test_reset_mid();
    test_push_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
